// File: rtl/ts_record_serializer.sv
// Packs timestamp records (id, start, end, delta) into a byte-wide AXI-Stream packet.
// Packet = MAGIC, seq, then RECS_PER_PKT records of 1 + 3*TS_W/8 bytes, multi-byte fields MSB first.
// First byte appears the cycle after a record is accepted; bytes advance only on m_tvalid && m_tready.
module ts_record_serializer #(
   parameter int          ID_W         = 4,
   parameter int          TS_W         = 64,
   parameter int          RECS_PER_PKT = 1,
   parameter logic [7:0]  MAGIC        = 8'h54
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [ID_W-1:0] in_id,
   input  logic [TS_W-1:0] in_start_ts,
   input  logic [TS_W-1:0] in_end_ts,
   input  logic [TS_W-1:0] in_delta,
   output logic [7:0]      m_tdata,
   output logic            m_tvalid,
   input  logic            m_tready,
   output logic            m_tlast,
   output logic [7:0]      seq_o
);

   localparam int TS_BYTES  = TS_W / 8;
   localparam int REC_BYTES = 1 + 3 * TS_BYTES;
   localparam int IDX_W     = $clog2(REC_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);
   localparam logic [7:0]       LAST_REC = 8'(RECS_PER_PKT - 1);

   typedef enum logic [1:0] {IDLE, HDR, REC, WAIT} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;
   logic [7:0]       rec_cnt;
   logic [7:0]       hold    [REC_BYTES];
   logic [7:0]       new_rec [REC_BYTES];
   logic             accept;
   logic             xfer;

   // Upstream is only served when no byte of a record is pending on the output side.
   assign in_ready = !rst && (state == IDLE || state == WAIT);
   assign accept   = in_valid && in_ready;
   assign xfer     = m_tvalid && m_tready;
   assign idx_nxt  = idx + 1'b1;

   // Lay the incoming record out in transmit order so emission is a plain byte index.
   always_comb begin
      new_rec[0] = 8'(in_id);
      for (int b = 0; b < TS_BYTES; b++) begin
         new_rec[1 + b]              = in_start_ts[(TS_BYTES-1-b)*8 +: 8];
         new_rec[1 + TS_BYTES + b]   = in_end_ts[(TS_BYTES-1-b)*8 +: 8];
         new_rec[1 + 2*TS_BYTES + b] = in_delta[(TS_BYTES-1-b)*8 +: 8];
      end
   end

   // Packet FSM; all stream outputs are registered and only change on reset, accept or transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         rec_cnt  <= '0;
         seq_o    <= '0;
         m_tdata  <= '0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
         hold     <= '{default: 8'h00};
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  hold     <= new_rec;
                  state    <= HDR;
                  idx      <= '0;
                  m_tvalid <= 1'b1;
                  m_tdata  <= MAGIC;
                  m_tlast  <= 1'b0;
               end
            end
            HDR: begin
               if (xfer) begin
                  if (idx == '0) begin
                     idx     <= idx_nxt;
                     m_tdata <= seq_o;
                  end else begin
                     state   <= REC;
                     idx     <= '0;
                     m_tdata <= hold[0];
                  end
               end
            end
            REC: begin
               if (xfer) begin
                  if (idx == LAST_IDX) begin
                     m_tvalid <= 1'b0;
                     m_tlast  <= 1'b0;
                     idx      <= '0;
                     if (rec_cnt == LAST_REC) begin
                        seq_o   <= seq_o + 8'd1;
                        rec_cnt <= '0;
                        state   <= IDLE;
                     end else begin
                        rec_cnt <= rec_cnt + 8'd1;
                        state   <= WAIT;
                     end
                  end else begin
                     idx     <= idx_nxt;
                     m_tdata <= hold[idx_nxt];
                     m_tlast <= (idx_nxt == LAST_IDX) && (rec_cnt == LAST_REC);
                  end
               end
            end
            WAIT: begin
               // The ID byte goes straight out while the rest lands in the holding register.
               if (accept) begin
                  hold     <= new_rec;
                  state    <= REC;
                  idx      <= '0;
                  m_tvalid <= 1'b1;
                  m_tdata  <= new_rec[0];
                  m_tlast  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ts_record_serializer.sv
// Bench for ts_record_serializer: two instances (1 and 2 records per packet) sharing stimulus.
// Expected byte streams come from a packet-level model built from record fields.
// Checks run in per-scenario tasks against a negedge stream monitor.
module tb_ts_record_serializer;

   typedef struct {
      logic [3:0]  id;
      logic [63:0] s;
      logic [63:0] e;
      logic [63:0] d;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        m_tready = 1'b1;
   logic [3:0]  in_id = '0;
   logic [63:0] in_start_ts = '0;
   logic [63:0] in_end_ts = '0;
   logic [63:0] in_delta = '0;

   logic       o1_ready, o1_tvalid, o1_tlast, o2_ready, o2_tvalid, o2_tlast;
   logic [7:0] o1_tdata, o1_seq, o2_tdata, o2_seq;

   always #5 clk = ~clk;

   ts_record_serializer #(.ID_W(4), .TS_W(64), .RECS_PER_PKT(1), .MAGIC(8'h54)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o1_ready), .in_id(in_id),
      .in_start_ts(in_start_ts), .in_end_ts(in_end_ts), .in_delta(in_delta),
      .m_tdata(o1_tdata), .m_tvalid(o1_tvalid), .m_tready(m_tready), .m_tlast(o1_tlast),
      .seq_o(o1_seq));

   ts_record_serializer #(.ID_W(4), .TS_W(64), .RECS_PER_PKT(2), .MAGIC(8'h54)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o2_ready), .in_id(in_id),
      .in_start_ts(in_start_ts), .in_end_ts(in_end_ts), .in_delta(in_delta),
      .m_tdata(o2_tdata), .m_tvalid(o2_tvalid), .m_tready(m_tready), .m_tlast(o2_tlast),
      .seq_o(o2_seq));

   bit         sel = 1'b0;
   wire        mon_ready  = sel ? o2_ready  : o1_ready;
   wire        mon_tvalid = sel ? o2_tvalid : o1_tvalid;
   wire        mon_tlast  = sel ? o2_tlast  : o1_tlast;
   wire [7:0]  mon_tdata  = sel ? o2_tdata  : o1_tdata;
   wire [7:0]  mon_seq    = sel ? o2_seq    : o1_seq;

   int tests = 0;
   int fails = 0;
   int timeouts = 0;
   bit done = 1'b0;

   // stream monitor state
   int         cyc = 0;
   int         stab_viol = 0;
   int         rdy_viol = 0;
   bit         pend = 1'b0;
   logic [7:0] pend_dat = '0;
   logic       pend_last = 1'b0;
   logic [7:0] got_q[$];
   bit         last_q[$];
   int         gcyc_q[$];
   int         acc_q[$];
   logic [7:0] exp_q[$];

   // Record every accepted byte and record handshake; flag AXI hold and in_ready violations.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (pend && !(mon_tvalid && mon_tdata === pend_dat && mon_tlast === pend_last))
         stab_viol <= stab_viol + 1;
      pend      <= mon_tvalid && !m_tready;
      pend_dat  <= mon_tdata;
      pend_last <= mon_tlast;
      if (mon_tvalid && mon_ready) rdy_viol <= rdy_viol + 1;
      if (mon_tvalid && m_tready) begin
         got_q.push_back(mon_tdata);
         last_q.push_back(mon_tlast);
         gcyc_q.push_back(cyc);
      end
      if (in_valid && mon_ready) acc_q.push_back(cyc);
   end

   // ---------------- reference model ----------------
   function automatic void model_pkt(input logic [7:0] seq, input rec_t r[$]);
      exp_q.push_back(8'h54);
      exp_q.push_back(seq);
      foreach (r[k]) begin
         exp_q.push_back({4'h0, r[k].id});
         for (int i = 7; i >= 0; i--) exp_q.push_back(8'((r[k].s >> (8 * i)) & 64'hFF));
         for (int i = 7; i >= 0; i--) exp_q.push_back(8'((r[k].e >> (8 * i)) & 64'hFF));
         for (int i = 7; i >= 0; i--) exp_q.push_back(8'((r[k].d >> (8 * i)) & 64'hFF));
      end
   endfunction

   function automatic rec_t rand_rec();
      rec_t r;
      r.id = 4'($urandom_range(0, 15));
      r.s  = {$urandom, $urandom};
      r.e  = {$urandom, $urandom};
      r.d  = {$urandom, $urandom};
      return r;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic clear_q();
      got_q.delete(); last_q.delete(); gcyc_q.delete(); acc_q.delete(); exp_q.delete();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b0; m_tready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clear_q();
   endtask

   task automatic send_rec(input rec_t r);
      int n = 0;
      in_valid = 1'b1; in_id = r.id; in_start_ts = r.s; in_end_ts = r.e; in_delta = r.d;
      @(negedge clk);
      while (!mon_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!mon_ready) begin
         timeouts++;
         $display("FAIL send_rec timeout: in_ready never rose (id %0h)", r.id);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_id = 4'($urandom); in_start_ts = {$urandom, $urandom};
   endtask

   task automatic wait_bytes(input int n, input int budget);
      int k = 0;
      while (got_q.size() < n && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      if (got_q.size() < n) begin
         timeouts++;
         $display("FAIL wait_bytes timeout: got %0d bytes, required %0d", got_q.size(), n);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++; if (o1_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid: got %b required 0", o1_tvalid); end
      tests++; if (o1_tdata !== 8'h00) begin fails++; $display("FAIL rst_tdata: got %h required 00", o1_tdata); end
      tests++; if (o1_tlast !== 1'b0) begin fails++; $display("FAIL rst_tlast: got %b required 0", o1_tlast); end
      tests++; if (o1_seq !== 8'h00) begin fails++; $display("FAIL rst_seq: got %h required 00", o1_seq); end
      tests++; if ({o1_ready, o2_ready} !== 2'b00) begin fails++; $display("FAIL rst_in_ready: got %b required 00", {o1_ready, o2_ready}); end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      tests++; if ({o1_tvalid, o1_tlast, o1_tdata, o1_seq} !== 18'h0) begin
         fails++; $display("FAIL post_rst_outputs: got %h required 0", {o1_tvalid, o1_tlast, o1_tdata, o1_seq}); end
      tests++; if ({o1_ready, o2_ready} !== 2'b11) begin fails++; $display("FAIL post_rst_in_ready: got %b required 11", {o1_ready, o2_ready}); end
   endtask

   task automatic test_single();
      rec_t r; rec_t rq[$];
      int t0 = timeouts;
      int bad = 0;
      sel = 1'b0;
      do_reset();
      r.id = 4'h3; r.s = 64'h10; r.e = 64'h25; r.d = 64'h15;
      rq.push_back(r);
      model_pkt(8'h00, rq);
      send_rec(r);
      wait_bytes(27, 200);
      repeat (3) @(negedge clk);
      tests++; if (timeouts !== t0) begin fails++; $display("FAIL single_timeout: got %0d required %0d", timeouts, t0); end
      tests++; if (got_q.size() !== 27) begin fails++; $display("FAIL single_len: got %0d required 27", got_q.size()); end
      for (int i = 0; i < 27; i++) begin
         logic [7:0] g = (i < got_q.size()) ? got_q[i] : 8'hxx;
         bit         l = (i < last_q.size()) ? last_q[i] : 1'b0;
         tests++; if (g !== exp_q[i]) begin fails++; $display("FAIL single_byte[%0d]: got %h required %h", i, g, exp_q[i]); end
         if (l !== (i == 26)) bad++;
      end
      tests++; if (bad !== 0) begin fails++; $display("FAIL single_tlast: %0d misplaced flags, required 0", bad); end
      tests++; if (acc_q.size() < 1 || gcyc_q.size() < 1 || gcyc_q[0] !== acc_q[0] + 1) begin
         fails++; $display("FAIL single_latency: first byte cycle %0d, required accept+1 (%0d)",
                           gcyc_q.size() ? gcyc_q[0] : -1, acc_q.size() ? acc_q[0] + 1 : -1); end
      tests++; if (o1_seq !== 8'h01) begin fails++; $display("FAIL single_seq: got %h required 01", o1_seq); end
   endtask

   task automatic test_two_rec();
      rec_t r1, r2; rec_t rq[$];
      int t0 = timeouts;
      int bad = 0;
      int lbad = 0;
      sel = 1'b1;
      do_reset();
      r1.id = 4'h1; r1.s = 64'h100; r1.e = 64'h180; r1.d = 64'h80;
      r2.id = 4'h2; r2.s = 64'h200; r2.e = 64'h2FF; r2.d = 64'hFF;
      rq.push_back(r1); rq.push_back(r2);
      model_pkt(8'h00, rq);
      send_rec(r1);
      send_rec(r2);
      wait_bytes(52, 300);
      repeat (3) @(negedge clk);
      tests++; if (timeouts !== t0) begin fails++; $display("FAIL two_timeout: got %0d required %0d", timeouts, t0); end
      tests++; if (got_q.size() !== 52) begin fails++; $display("FAIL two_len: got %0d required 52", got_q.size()); end
      for (int i = 0; i < 52; i++) begin
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
         if (i < last_q.size() && last_q[i] !== (i == 51)) lbad++;
      end
      tests++; if (bad !== 0) begin fails++; $display("FAIL two_stream: %0d wrong bytes, required 0", bad); end
      tests++; if (lbad !== 0) begin fails++; $display("FAIL two_tlast: %0d misplaced flags, required 0", lbad); end
      if (got_q.size() >= 28) begin
         tests++; if (got_q[27] !== 8'h02) begin fails++; $display("FAIL two_id_byte28: got %h required 02", got_q[27]); end
         tests++; if (gcyc_q[27] - gcyc_q[26] !== 2) begin
            fails++; $display("FAIL two_bubble: gap %0d cycles required 2", gcyc_q[27] - gcyc_q[26]); end
      end
      tests++; if (o2_seq !== 8'h01) begin fails++; $display("FAIL two_seq: got %h required 01", o2_seq); end
   endtask

   task automatic test_backpressure();
      rec_t r; rec_t rq[$];
      rec_t recs[4];
      int t0 = timeouts;
      int s0 = stab_viol;
      int v0 = rdy_viol;
      int bad = 0;
      sel = 1'b0;
      do_reset();
      recs[0].id = 4'h3; recs[0].s = 64'h10; recs[0].e = 64'h25; recs[0].d = 64'h15;
      for (int k = 1; k < 4; k++) recs[k] = rand_rec();
      for (int k = 0; k < 4; k++) begin
         rq.delete(); rq.push_back(recs[k]);
         model_pkt(8'(k), rq);
      end
      done = 1'b0;
      fork
         begin
            for (int k = 0; k < 4; k++) send_rec(recs[k]);
            wait_bytes(108, 3000);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               m_tready = $urandom_range(0, 1) == 1;
            end
         end
      join
      m_tready = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (timeouts !== t0) begin fails++; $display("FAIL bp_timeout: got %0d required %0d", timeouts, t0); end
      tests++; if (got_q.size() !== 108) begin fails++; $display("FAIL bp_len: got %0d required 108", got_q.size()); end
      for (int i = 0; i < 108; i++)
         if (i >= got_q.size() || got_q[i] !== exp_q[i] || last_q[i] !== (i % 27 == 26)) bad++;
      tests++; if (bad !== 0) begin fails++; $display("FAIL bp_stream: %0d wrong bytes, required 0", bad); end
      tests++; if (stab_viol !== s0) begin fails++; $display("FAIL bp_hold_stable: %0d violations, required 0", stab_viol - s0); end
      tests++; if (rdy_viol !== v0) begin fails++; $display("FAIL bp_in_ready_busy: %0d violations, required 0", rdy_viol - v0); end
   endtask

   task automatic test_seq_wrap();
      rec_t r; rec_t rq[$];
      int t0 = timeouts;
      int bad = 0;
      sel = 1'b0;
      do_reset();
      for (int p = 0; p < 257; p++) begin
         r = rand_rec();
         rq.delete(); rq.push_back(r);
         model_pkt(8'(p % 256), rq);
         send_rec(r);
      end
      wait_bytes(257 * 27, 1000);
      repeat (3) @(negedge clk);
      tests++; if (timeouts !== t0) begin fails++; $display("FAIL wrap_timeout: got %0d required %0d", timeouts, t0); end
      tests++; if (got_q.size() !== 257 * 27) begin fails++; $display("FAIL wrap_len: got %0d required %0d", got_q.size(), 257 * 27); end
      for (int p = 0; p < 257; p++) begin
         logic [7:0] g = (p * 27 + 1 < got_q.size()) ? got_q[p * 27 + 1] : 8'hxx;
         tests++; if (g !== 8'(p % 256)) begin fails++; $display("FAIL wrap_seq[%0d]: got %h required %h", p, g, 8'(p % 256)); end
      end
      for (int i = 0; i < 257 * 27; i++)
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
      tests++; if (bad !== 0) begin fails++; $display("FAIL wrap_stream: %0d wrong bytes, required 0", bad); end
      tests++; if (o1_seq !== 8'h01) begin fails++; $display("FAIL wrap_seq_o: got %h required 01", o1_seq); end
   endtask

   task automatic test_reset_mid();
      rec_t r; rec_t rq[$];
      int t0 = timeouts;
      int bad = 0;
      int lcnt = 0;
      sel = 1'b0;
      do_reset();
      send_rec(rand_rec());
      wait_bytes(27, 200);
      repeat (2) @(negedge clk);
      @(posedge clk); #1 clear_q();
      send_rec(rand_rec());
      wait_bytes(10, 200);
      // byte 10 is on the bus now; reset lands before it can be taken
      rst = 1'b1;
      @(negedge clk);
      tests++; if (o1_tvalid !== 1'b0) begin fails++; $display("FAIL mid_rst_tvalid: got %b required 0", o1_tvalid); end
      tests++; if (o1_seq !== 8'h00) begin fails++; $display("FAIL mid_rst_seq: got %h required 00", o1_seq); end
      foreach (last_q[i]) if (last_q[i]) lcnt++;
      tests++; if (lcnt !== 0 || o1_tlast !== 1'b0) begin
         fails++; $display("FAIL mid_rst_tlast: %0d tlast bytes, tlast now %b, required none", lcnt, o1_tlast); end
      @(posedge clk); #1 rst = 1'b0;
      clear_q();
      r = rand_rec();
      rq.push_back(r);
      model_pkt(8'h00, rq);
      send_rec(r);
      wait_bytes(27, 200);
      repeat (3) @(negedge clk);
      tests++; if (timeouts !== t0) begin fails++; $display("FAIL mid_timeout: got %0d required %0d", timeouts, t0); end
      tests++; if (got_q.size() !== 27) begin fails++; $display("FAIL mid_len: got %0d required 27", got_q.size()); end
      for (int i = 0; i < 27; i++)
         if (i >= got_q.size() || got_q[i] !== exp_q[i] || last_q[i] !== (i == 26)) bad++;
      tests++; if (bad !== 0) begin fails++; $display("FAIL mid_stream: %0d wrong bytes, required 0", bad); end
   endtask

   task automatic test_back_to_back();
      rec_t r; rec_t rq[$];
      int t0 = timeouts;
      int bad = 0;
      int abad = 0;
      sel = 1'b0;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         r = rand_rec();
         rq.delete(); rq.push_back(r);
         model_pkt(8'(k), rq);
         send_rec(r);
      end
      wait_bytes(108, 400);
      repeat (3) @(negedge clk);
      tests++; if (timeouts !== t0) begin fails++; $display("FAIL b2b_timeout: got %0d required %0d", timeouts, t0); end
      tests++; if (got_q.size() !== 108) begin fails++; $display("FAIL b2b_len: got %0d required 108", got_q.size()); end
      for (int i = 0; i < 108; i++)
         if (i >= got_q.size() || got_q[i] !== exp_q[i] || last_q[i] !== (i % 27 == 26)) bad++;
      tests++; if (bad !== 0) begin fails++; $display("FAIL b2b_stream: %0d wrong bytes, required 0", bad); end
      for (int k = 0; k < 4; k++) begin
         logic [7:0] g = (k * 27 + 1 < got_q.size()) ? got_q[k * 27 + 1] : 8'hxx;
         tests++; if (g !== 8'(k)) begin fails++; $display("FAIL b2b_seq[%0d]: got %h required %h", k, g, 8'(k)); end
      end
      tests++; if (acc_q.size() !== 4) begin fails++; $display("FAIL b2b_accepts: got %0d required 4", acc_q.size()); end
      for (int k = 1; k < 4; k++)
         if (k >= acc_q.size() || 27 * k - 1 >= gcyc_q.size() || acc_q[k] !== gcyc_q[27 * k - 1] + 1) abad++;
      tests++; if (abad !== 0) begin fails++; $display("FAIL b2b_accept_idle: %0d accepts not right after tlast, required 0", abad); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_two_rec();
      test_backpressure();
      test_seq_wrap();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ts_record_serializer.md
Name: ts_record_serializer

Overview:
- Consumer of the timestamp record stream (id, start_ts, end_ts, delta) emitted by the event timestamper.
- Packs records into a byte-wide AXI-Stream payload for the UDP transmit path.
- Groups RECS_PER_PKT records per packet and prefixes each packet with a magic byte and a sequence number.
- Marks the final byte of each packet with m_tlast.

Parameters:
- ID_W, 4: event ID width; legal range 1..8.
- TS_W, 64: timestamp width; must be a multiple of 8, range 8..64.
- RECS_PER_PKT, 1: records per packet; range 1..255.
- MAGIC, 8'h54: first header byte of every packet.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  record offered
- in_ready  out  1  serializer can accept a record
- in_id  in  ID_W  event ID
- in_start_ts  in  TS_W  start timestamp
- in_end_ts  in  TS_W  end timestamp
- in_delta  in  TS_W  end minus start
- m_tdata  out  8  payload byte
- m_tvalid  out  1  byte valid
- m_tready  in  1  downstream accepts byte
- m_tlast  out  1  last byte of packet
- seq_o  out  8  sequence number that the next packet will carry

Behaviour:
- Reset is synchronous, active-high, on clk. While rst is high and on the first cycle after it:
  - m_tvalid=0, m_tdata=0, m_tlast=0, seq_o=0.
  - State = IDLE; record counter and byte counter = 0.
  - in_ready=0 while rst is high.
- Record layout, REC_BYTES = 1 + 3*TS_W/8 (25 at defaults):
  - in_id zero-extended to 8 bits.
  - start_ts, MSB byte first.
  - end_ts, MSB byte first.
  - delta, MSB byte first.
- Packet layout: MAGIC, seq, then RECS_PER_PKT records. PKT_BYTES = 2 + RECS_PER_PKT*REC_BYTES.
- Input handshake:
  - A transfer occurs when in_valid && in_ready.
  - On a transfer, all four fields are latched into a holding register; inputs are don't-care otherwise.
  - in_ready=1 only in states IDLE and WAIT, and only when not in reset.
- FSM:
  - IDLE: no packet open. On accept -> HDR, with byte index 0.
  - HDR: emits MAGIC, then seq. After seq is accepted -> REC, with byte index 0.
  - REC: emits holding-register bytes in layout order. After the last record byte is accepted:
    - If record count == RECS_PER_PKT-1: seq++, record count=0 -> IDLE.
    - Otherwise: record count++ -> WAIT.
  - WAIT: packet open, awaiting the next record. On accept -> REC, with byte index 0.
- Output timing:
  - Outputs are registered.
  - A record accepted in cycle T has m_tvalid=1 with its first byte (MAGIC, or ID byte if in WAIT) in cycle T+1.
  - A byte advances only when m_tvalid && m_tready. With m_tready held high, one byte is emitted per cycle.
  - One bubble cycle occurs between records inside a packet (WAIT accept cycle); this is intended.
- AXI-Stream rules:
  - Once m_tvalid=1, m_tdata and m_tlast hold stable until accepted.
  - m_tvalid never drops without a transfer, except on reset.
  - m_tlast=1 only on the last record byte of record RECS_PER_PKT-1.
- Sequence number:
  - seq_o increments on the cycle after the tlast byte is accepted.
  - Wraps 255 -> 0.
  - The header carries the seq_o value at packet start.
- Backpressure: with m_tready held low indefinitely, the block holds the current byte and the holding register; in_ready stays 0 outside IDLE/WAIT. No records are dropped.
- Reset mid-packet: the packet is abandoned with no tlast; m_tvalid=0 next cycle; seq restarts at 0.
- in_valid in HDR/REC is ignored and must stay asserted by the upstream until accepted.

Test Plan:
- Single packet: RECS_PER_PKT=1, id=3, start=0x10, end=0x25, delta=0x15, m_tready=1. Required stream:
  - 27 bytes: 54, 00, 03, 7×00, 10, 7×00, 25, 7×00, 15.
  - m_tlast only on byte 27; m_tvalid first high the cycle after acceptance; seq_o=1 afterwards.
- Two-record packet: RECS_PER_PKT=2, records (1, 0x100, 0x180, 0x80) and (2, 0x200, 0x2FF, 0xFF) back-to-back. Required:
  - 52 bytes, header 54 00.
  - ID byte 02 at byte 28.
  - One bubble cycle between byte 27 and byte 28.
  - m_tlast only on byte 52.
- Backpressure: toggle m_tready randomly 50%. Required:
  - Identical byte sequence to the single-packet test.
  - m_tdata and m_tlast stable while m_tvalid && !m_tready.
  - in_ready=0 throughout HDR/REC.
- Sequence wrap: send 257 single-record packets. Required:
  - Header seq bytes run 00..FF, then 00.
  - seq_o=1 at the end.
- Reset mid-packet: assert rst during byte 10. Required:
  - m_tvalid=0 the next cycle; no m_tlast.
  - A following record produces a full 27-byte packet with seq 00.
- Back-to-back packets: in_valid held high with 4 records, RECS_PER_PKT=1. Required:
  - Each packet is 27 bytes.
  - Each accept occurs only in IDLE.
  - Seq bytes are 00, 01, 02, 03.
